// File: rtl/monitored_ram_pkg.sv
// Shared definitions for the monitored RAM and the cache that embeds it:
// default widths, read/write encoding and the per-edge operation decode.
package monitored_ram_pkg;

  localparam int D_WIDTH_DEF = 8;
  localparam int A_WIDTH_DEF = 8;
  localparam int DEPTH_DEF   = 8;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  // Clear is resolved in the register process; this covers only enab/rw.
  function automatic op_e decode_op(input logic enab, input logic rw);
    op_e op;
    if (!enab) begin
      op = OP_IDLE;
    end else if (rw == RW_WRITE) begin
      op = OP_WRITE;
    end else begin
      op = OP_READ;
    end
    return op;
  endfunction

endpackage

// File: rtl/monitored_ram_if.sv
// Access bus of the monitored RAM: enable, direction, address, write data and
// registered read data. The requester uses master, the RAM uses slave.
interface monitored_ram_if #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8
);

  logic               enab;
  logic               rw;
  logic [A_WIDTH-1:0] Addr;
  logic [D_WIDTH-1:0] data_in;
  logic [D_WIDTH-1:0] data_out;

  modport master (
    output enab,
    output rw,
    output Addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  enab,
    input  rw,
    input  Addr,
    input  data_in,
    output data_out
  );

endinterface

// File: rtl/monitored_ram.sv
// Single-port synchronous RAM with registered read, synchronous active-low
// clear and continuous monitor outputs for words 0..7.
module monitored_ram
  import monitored_ram_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               clr,
  monitored_ram_if.slave     bus,
  output logic [D_WIDTH-1:0] mem0,
  output logic [D_WIDTH-1:0] mem1,
  output logic [D_WIDTH-1:0] mem2,
  output logic [D_WIDTH-1:0] mem3,
  output logic [D_WIDTH-1:0] mem4,
  output logic [D_WIDTH-1:0] mem5,
  output logic [D_WIDTH-1:0] mem6,
  output logic [D_WIDTH-1:0] mem7
);

  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (DEPTH < 8) begin : g_depth_min
      $error("monitored_ram: DEPTH must be at least 8");
    end
    if ((1 << IDX_W) != DEPTH) begin : g_depth_pow2
      $error("monitored_ram: DEPTH must be a power of 2");
    end
    if (IDX_W > A_WIDTH) begin : g_depth_addr
      $error("monitored_ram: DEPTH exceeds the address range");
    end
  endgenerate

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] mem_d [DEPTH];
  logic [D_WIDTH-1:0] data_out_q;
  logic [D_WIDTH-1:0] data_out_d;
  logic [IDX_W-1:0]   idx;
  op_e                op;

  // Upper address bits are deliberately dropped so addresses wrap modulo DEPTH.
  assign idx = bus.Addr[IDX_W-1:0];

  generate
    if (IDX_W < A_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.Addr[A_WIDTH-1:IDX_W];
    end
  endgenerate

  always_comb begin
    mem_d      = mem_q;
    data_out_d = data_out_q;
    op         = decode_op(bus.enab, bus.rw);
    case (op)
      OP_WRITE: mem_d[idx]  = bus.data_in;
      OP_READ:  data_out_d  = mem_q[idx];
      default:  ;
    endcase
  end

  // Clear wins over any access presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      data_out_q <= '0;
    end else begin
      mem_q      <= mem_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

  logic [D_WIDTH-1:0] mon [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mon
      assign mon[gi] = mem_q[gi];
    end
  endgenerate

  assign mem0 = mon[0];
  assign mem1 = mon[1];
  assign mem2 = mon[2];
  assign mem3 = mon[3];
  assign mem4 = mon[4];
  assign mem5 = mon[5];
  assign mem6 = mon[6];
  assign mem7 = mon[7];

endmodule

// File: tb/tb_monitored_ram.sv
// Directed self-checking bench for monitored_ram (DEPTH=8, 8-bit data/address).
module tb_monitored_ram;

  logic clk;
  logic clr;
  logic [7:0] mem0, mem1, mem2, mem3, mem4, mem5, mem6, mem7;
  logic [7:0] mon [8];

  int errors;
  int checks;

  monitored_ram_if #(.D_WIDTH(8), .A_WIDTH(8)) bus ();

  monitored_ram #(.D_WIDTH(8), .A_WIDTH(8), .DEPTH(8)) dut (
    .clk  (clk),
    .clr  (clr),
    .bus  (bus),
    .mem0 (mem0),
    .mem1 (mem1),
    .mem2 (mem2),
    .mem3 (mem3),
    .mem4 (mem4),
    .mem5 (mem5),
    .mem6 (mem6),
    .mem7 (mem7)
  );

  assign mon[0] = mem0;
  assign mon[1] = mem1;
  assign mon[2] = mem2;
  assign mon[3] = mem3;
  assign mon[4] = mem4;
  assign mon[5] = mem5;
  assign mon[6] = mem6;
  assign mon[7] = mem7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic w, input logic [7:0] a, input logic [7:0] d);
    bus.enab    = en;
    bus.rw      = w;
    bus.Addr    = a;
    bus.data_in = d;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mon[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_mem%0d got=%h want=00", i, mon[i]);
      end
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_out got=%h want=00", bus.data_out);
    end
    $display("reset: clr pulse applied");
  endtask

  task automatic test_write_read();
    drive(1'b1, 1'b1, 8'd5, 8'hA7);
    step();
    checks++;
    if (mem5 !== 8'hA7) begin
      errors++;
      $display("FAIL wr_mem5 got=%h want=a7", mem5);
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL wr_data_out_hold got=%h want=00", bus.data_out);
    end
    $display("write addr=05 data=a7");
    drive(1'b1, 1'b0, 8'd5, 8'h00);
    step();
    checks++;
    if (bus.data_out !== 8'hA7) begin
      errors++;
      $display("FAIL rd_addr5 got=%h want=a7", bus.data_out);
    end
    $display("read addr=05 data_out=%h", bus.data_out);
  endtask

  task automatic test_disable();
    drive(1'b0, 1'b1, 8'd2, 8'h33);
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (mem2 !== 8'h00) begin
        errors++;
        $display("FAIL dis_mem2 cycle=%0d got=%h want=00", c, mem2);
      end
      checks++;
      if (bus.data_out !== 8'hA7) begin
        errors++;
        $display("FAIL dis_data_out cycle=%0d got=%h want=a7", c, bus.data_out);
      end
      $display("disabled cycle %0d addr=02 data=33", c);
    end
  endtask

  task automatic test_alias();
    drive(1'b1, 1'b1, 8'h0B, 8'h5C);
    step();
    checks++;
    if (mem3 !== 8'h5C) begin
      errors++;
      $display("FAIL alias_mem3 got=%h want=5c", mem3);
    end
    $display("write addr=0b data=5c");
    drive(1'b1, 1'b0, 8'h03, 8'h00);
    step();
    checks++;
    if (bus.data_out !== 8'h5C) begin
      errors++;
      $display("FAIL alias_rd3 got=%h want=5c", bus.data_out);
    end
    $display("read addr=03 data_out=%h", bus.data_out);
    drive(1'b1, 1'b0, 8'hFD, 8'h00);
    step();
    checks++;
    if (bus.data_out !== 8'hA7) begin
      errors++;
      $display("FAIL alias_rdfd got=%h want=a7", bus.data_out);
    end
    $display("read addr=fd data_out=%h", bus.data_out);
  endtask

  task automatic test_clear_priority();
    drive(1'b1, 1'b1, 8'd1, 8'h42);
    step();
    checks++;
    if (mem1 !== 8'h42) begin
      errors++;
      $display("FAIL clrp_pre_mem1 got=%h want=42", mem1);
    end
    clr = 1'b0;
    drive(1'b1, 1'b1, 8'd1, 8'hFF);
    step();
    clr = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mon[i] !== 8'h00) begin
        errors++;
        $display("FAIL clrp_mem%0d got=%h want=00", i, mon[i]);
      end
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL clrp_data_out got=%h want=00", bus.data_out);
    end
    $display("clear with write addr=01 data=ff");
  endtask

  task automatic test_back_to_back();
    logic [7:0] val;
    for (int i = 0; i < 8; i++) begin
      val = 8'((i + 1) * 8'h11);
      drive(1'b1, 1'b1, 8'(i), val);
      step();
      checks++;
      if (mon[i] !== val) begin
        errors++;
        $display("FAIL b2b_wr%0d got=%h want=%h", i, mon[i], val);
      end
      checks++;
      if (bus.data_out !== 8'h00) begin
        errors++;
        $display("FAIL b2b_wr_hold%0d got=%h want=00", i, bus.data_out);
      end
      $display("write addr=%02h data=%h", i, val);
    end
    for (int i = 7; i >= 0; i--) begin
      val = 8'((i + 1) * 8'h11);
      drive(1'b1, 1'b0, 8'(i), 8'h00);
      step();
      checks++;
      if (bus.data_out !== val) begin
        errors++;
        $display("FAIL b2b_rd%0d got=%h want=%h", i, bus.data_out, val);
      end
      $display("read addr=%02h data_out=%h", i, bus.data_out);
    end
  endtask

  task automatic test_clear_midsequence();
    drive(1'b1, 1'b1, 8'd0, 8'h99);
    step();
    clr = 1'b0;
    drive(1'b1, 1'b1, 8'd6, 8'h77);
    step();
    clr = 1'b1;
    drive(1'b1, 1'b1, 8'd2, 8'h22);
    step();
    checks++;
    if (mem2 !== 8'h22) begin
      errors++;
      $display("FAIL mid_mem2 got=%h want=22", mem2);
    end
    checks++;
    if (mem0 !== 8'h00) begin
      errors++;
      $display("FAIL mid_mem0 got=%h want=00", mem0);
    end
    checks++;
    if (mem6 !== 8'h00) begin
      errors++;
      $display("FAIL mid_mem6 got=%h want=00", mem6);
    end
    $display("clear mid-sequence then write addr=02 data=22");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clr = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    step();
    test_reset();
    test_write_read();
    test_disable();
    test_alias();
    test_clear_priority();
    test_back_to_back();
    test_clear_midsequence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
